// File: rtl/img_vga_pkg.sv
// Shared types and width helpers for the image-to-VGA streamer.
package img_vga_pkg;

  typedef enum logic {LOAD = 1'b0, STREAM = 1'b1} state_t;
  typedef enum logic {MODE_TILE = 1'b0, MODE_SCALE = 1'b1} mode_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int pix_idx_w(input int w, input int h);
    return cnt_w(w * h);
  endfunction

endpackage

// File: rtl/img_pix_buf.sv
// Image store: beat-wide write port, pixel-wide registered read port.
module img_pix_buf import img_vga_pkg::*; #(
  parameter int PIX_W    = 8,
  parameter int BEAT_PIX = 16,
  parameter int NBEATS   = 49,
  parameter int IDX_W    = 10,
  parameter int WORD_W   = cnt_w(NBEATS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [WORD_W-1:0]         wr_addr,
  input  logic [BEAT_PIX*PIX_W-1:0] wr_data,
  input  logic                      rd_en,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic [PIX_W-1:0]          rd_pix
);

  localparam int LANE_SH = $clog2(BEAT_PIX);
  localparam int LANE_W  = cnt_w(BEAT_PIX);
  localparam int DW      = BEAT_PIX * PIX_W;

  logic [DW-1:0]     mem [NBEATS];
  logic [WORD_W-1:0] rd_word_s;
  logic [LANE_W-1:0] rd_lane_s;
  logic [DW-1:0]     rd_data_s;

  // Word/lane split; a read of the word being written sees the new beat.
  always_comb begin
    rd_word_s = WORD_W'(rd_idx >> LANE_SH);
    rd_lane_s = LANE_W'(rd_idx) & LANE_W'(BEAT_PIX - 1);
    if (wr_en && (wr_addr == rd_word_s)) begin
      rd_data_s = wr_data;
    end else begin
      rd_data_s = mem[rd_word_s];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pix <= '0;
    end else if (rd_en) begin
      rd_pix <= rd_data_s[rd_lane_s*PIX_W +: PIX_W];
    end
  end

endmodule

// File: rtl/img_tile_vga_stream.sv
// Captures one greyscale image from wide beats, then streams one VGA raster
// that either tiles the image or shows a centred integer-scaled copy.
module img_tile_vga_stream import img_vga_pkg::*; #(
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int PIX_W    = 8,
  parameter int BEAT_PIX = 16,
  parameter int SCR_W    = 640,
  parameter int SCR_H    = 480,
  parameter int OUT_W    = 12,
  parameter int SCALE    = 8
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic [BEAT_PIX*PIX_W-1:0] iDATA,
  input  logic                      iDVAL,
  output logic                      oIN_RDY,
  input  logic                      iMODE,
  input  logic [OUT_W-1:0]          iBORDER,
  input  logic                      iRDY,
  output logic [OUT_W-1:0]          ovgaDATA,
  output logic                      ovgaDVAL,
  output logic                      ovgaSOF,
  output logic                      ovgaEOF
);

  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NBEATS = (NPIX + BEAT_PIX - 1) / BEAT_PIX;
  localparam int IDX_W  = pix_idx_w(IMG_W, IMG_H);
  localparam int WORD_W = cnt_w(NBEATS);
  localparam int SX_W   = cnt_w(SCR_W);
  localparam int SY_W   = cnt_w(SCR_H);
  localparam int PH_W   = cnt_w(SCALE);
  localparam int OX     = (SCR_W - SCALE * IMG_W) / 2;
  localparam int OY     = (SCR_H - SCALE * IMG_H) / 2;

  localparam logic [WORD_W-1:0] BEAT_LAST = WORD_W'(NBEATS - 1);
  localparam logic [SX_W-1:0]   SX_LAST   = SX_W'(SCR_W - 1);
  localparam logic [SY_W-1:0]   SY_LAST   = SY_W'(SCR_H - 1);
  localparam logic [IDX_W-1:0]  TX_LAST   = IDX_W'(IMG_W - 1);
  localparam logic [IDX_W-1:0]  TY_LAST   = IDX_W'(IMG_H - 1);
  localparam logic [IDX_W-1:0]  ROW_STEP  = IDX_W'(IMG_W);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(SCALE - 1);

  if (SCALE * IMG_W > SCR_W || SCALE * IMG_H > SCR_H) begin : g_bad_scale
    $error("img_tile_vga_stream: scaled image does not fit the screen");
  end

  state_t               state_r;
  mode_t                mode_r, mode_s;
  logic                 in_rdy_r, issued_all_r;
  logic [WORD_W-1:0]    beat_r;
  logic [SX_W-1:0]      sx_r;
  logic [SY_W-1:0]      sy_r;
  logic [IDX_W-1:0]     tx_r, ty_r, tile_base_r, ix_r, scale_base_r, rd_idx_s;
  logic [PH_W-1:0]      px_r, py_r;
  logic                 s1_valid_r, s1_sof_r, s1_eof_r, s1_border_r;
  logic                 out_dval_r, out_sof_r, out_eof_r;
  logic [OUT_W-1:0]     out_data_r, fmt_s;
  logic [PIX_W-1:0]     pix_s;
  logic [PIX_W+OUT_W-1:0] wide_s;
  logic                 in_x_s, in_y_s, last_beat_s, adv_out_s, adv_s1_s, issue_s, eof_acc_s;

  // The first pixel is issued in the same cycle as the final beat, so the
  // mode is taken live in LOAD and from the latched copy in STREAM.
  always_comb begin
    in_x_s      = (int'(sx_r) >= OX) && (int'(sx_r) < OX + SCALE * IMG_W);
    in_y_s      = (int'(sy_r) >= OY) && (int'(sy_r) < OY + SCALE * IMG_H);
    if (state_r == LOAD) begin
      mode_s = mode_t'(iMODE);
    end else begin
      mode_s = mode_r;
    end
    last_beat_s = (state_r == LOAD) && iDVAL && (beat_r == BEAT_LAST);
    adv_out_s   = !out_dval_r || iRDY;
    adv_s1_s    = !s1_valid_r || adv_out_s;
    issue_s     = adv_s1_s && (last_beat_s || ((state_r == STREAM) && !issued_all_r));
    eof_acc_s   = out_dval_r && out_eof_r && iRDY;
    if (mode_s == MODE_TILE) begin
      rd_idx_s = tile_base_r + tx_r;
    end else begin
      rd_idx_s = scale_base_r + ix_r;
    end
    wide_s = {pix_s, OUT_W'(0)};
    fmt_s  = wide_s[PIX_W+OUT_W-1 -: OUT_W];
  end

  img_pix_buf #(
    .PIX_W(PIX_W), .BEAT_PIX(BEAT_PIX), .NBEATS(NBEATS), .IDX_W(IDX_W), .WORD_W(WORD_W)
  ) u_buf (
    .clk(iCLK), .rst_n(iRST),
    .wr_en((state_r == LOAD) && iDVAL), .wr_addr(beat_r), .wr_data(iDATA),
    .rd_en(issue_s), .rd_idx(rd_idx_s), .rd_pix(pix_s)
  );

  // LOAD/STREAM sequencing with beat counter and registered ready.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_r  <= LOAD;
      in_rdy_r <= 1'b1;
      beat_r   <= '0;
      mode_r   <= MODE_TILE;
    end else begin
      case (state_r)
        LOAD: begin
          if (iDVAL) begin
            if (beat_r == BEAT_LAST) begin
              beat_r   <= '0;
              state_r  <= STREAM;
              in_rdy_r <= 1'b0;
              mode_r   <= mode_t'(iMODE);
            end else begin
              beat_r <= beat_r + WORD_W'(1);
            end
          end
        end
        STREAM: begin
          if (eof_acc_s) begin
            state_r  <= LOAD;
            in_rdy_r <= 1'b1;
          end
        end
        default: begin
          state_r  <= LOAD;
          in_rdy_r <= 1'b1;
        end
      endcase
    end
  end

  // Screen position of the next pixel to issue, with tile wrap and scale phase.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      sx_r <= '0; sy_r <= '0; tx_r <= '0; ty_r <= '0; tile_base_r <= '0;
      px_r <= '0; py_r <= '0; ix_r <= '0; scale_base_r <= '0;
      issued_all_r <= 1'b0;
    end else begin
      if (eof_acc_s) begin
        issued_all_r <= 1'b0;
      end
      if (issue_s) begin
        if (sx_r == SX_LAST) begin
          sx_r <= '0; tx_r <= '0; px_r <= '0; ix_r <= '0;
          if (sy_r == SY_LAST) begin
            sy_r <= '0; ty_r <= '0; tile_base_r <= '0; py_r <= '0; scale_base_r <= '0;
            issued_all_r <= 1'b1;
          end else begin
            sy_r <= sy_r + SY_W'(1);
            if (ty_r == TY_LAST) begin
              ty_r <= '0; tile_base_r <= '0;
            end else begin
              ty_r <= ty_r + IDX_W'(1); tile_base_r <= tile_base_r + ROW_STEP;
            end
            if (in_y_s) begin
              if (py_r == PH_LAST) begin
                py_r <= '0; scale_base_r <= scale_base_r + ROW_STEP;
              end else begin
                py_r <= py_r + PH_W'(1);
              end
            end
          end
        end else begin
          sx_r <= sx_r + SX_W'(1);
          if (tx_r == TX_LAST) begin
            tx_r <= '0;
          end else begin
            tx_r <= tx_r + IDX_W'(1);
          end
          if (in_x_s) begin
            if (px_r == PH_LAST) begin
              px_r <= '0; ix_r <= ix_r + IDX_W'(1);
            end else begin
              px_r <= px_r + PH_W'(1);
            end
          end
        end
      end
    end
  end

  // Read-stage sideband and output register, both gated by downstream ready.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      s1_valid_r <= 1'b0; s1_sof_r <= 1'b0; s1_eof_r <= 1'b0; s1_border_r <= 1'b0;
      out_dval_r <= 1'b0; out_sof_r <= 1'b0; out_eof_r <= 1'b0; out_data_r <= '0;
    end else begin
      if (adv_s1_s) begin
        s1_valid_r  <= issue_s;
        s1_sof_r    <= issue_s && (sx_r == '0) && (sy_r == '0);
        s1_eof_r    <= issue_s && (sx_r == SX_LAST) && (sy_r == SY_LAST);
        s1_border_r <= (mode_s == MODE_SCALE) && !(in_x_s && in_y_s);
      end
      if (adv_out_s) begin
        out_dval_r <= s1_valid_r;
        out_sof_r  <= s1_valid_r && s1_sof_r;
        out_eof_r  <= s1_valid_r && s1_eof_r;
        if (s1_valid_r) begin
          out_data_r <= s1_border_r ? iBORDER : fmt_s;
        end
      end
    end
  end

  assign oIN_RDY  = in_rdy_r;
  assign ovgaDVAL = out_dval_r;
  assign ovgaDATA = out_data_r;
  assign ovgaSOF  = out_sof_r;
  assign ovgaEOF  = out_eof_r;

endmodule
